// File: rtl/gpu_regfile_mt_if.sv
// gpu_regfile_mt_if: writeback, read, scoreboard and bank-clear signals of the multithreaded register file
interface gpu_regfile_mt_if #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 5,
  parameter int NUM_THR = 4
);
  localparam int TID_W = NUM_THR > 1 ? $clog2(NUM_THR) : 1;
  logic              we;
  logic [TID_W-1:0]  w_tid;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic [TID_W-1:0]  r_tid;
  logic [ADDR_W-1:0] r_addr_a, r_addr_b, r_addr_c;
  logic [DATA_W-1:0] r_data_a, r_data_b, r_data_c;
  logic              busy_a, busy_b, busy_c;
  logic              sb_set;
  logic [TID_W-1:0]  sb_tid;
  logic [ADDR_W-1:0] sb_addr;
  logic              clr_req;
  logic [TID_W-1:0]  clr_tid;
  logic              clr_busy, clr_done;
  modport master (
    output we, w_tid, w_addr, w_data, r_tid, r_addr_a, r_addr_b, r_addr_c,
           sb_set, sb_tid, sb_addr, clr_req, clr_tid,
    input  r_data_a, r_data_b, r_data_c, busy_a, busy_b, busy_c, clr_busy, clr_done
  );
  modport slave (
    input  we, w_tid, w_addr, w_data, r_tid, r_addr_a, r_addr_b, r_addr_c,
           sb_set, sb_tid, sb_addr, clr_req, clr_tid,
    output r_data_a, r_data_b, r_data_c, busy_a, busy_b, busy_c, clr_busy, clr_done
  );
endinterface

// File: rtl/gpu_regfile_mt.sv
// gpu_regfile_mt: per-thread register banks with write-through bypass, pending-write scoreboard and bank clear
module gpu_regfile_mt #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 5,
  parameter int NUM_THR = 4
) (
  input logic clk,
  input logic rst,
  gpu_regfile_mt_if.slave bus
);
  localparam int TID_W = NUM_THR > 1 ? $clog2(NUM_THR) : 1;
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [TID_W-1:0]  tid_q, tid_d;
  logic [DATA_W-1:0] mem_q [NUM_THR][DEPTH];
  logic [DATA_W-1:0] mem_d [NUM_THR][DEPTH];
  logic [DEPTH-1:0]  busy_q [NUM_THR];
  logic [DEPTH-1:0]  busy_d [NUM_THR];
  logic              clearing, last, wr_ok, sb_ok;
  logic [ADDR_W-1:0] ra [3];
  logic [DATA_W-1:0] rd [3];
  logic [2:0]        rb;
  assign clearing = state_q == CLEAR;
  assign last     = cnt_q == ADDR_W'(DEPTH - 1);
  assign wr_ok    = bus.we && bus.w_addr != '0 && !(clearing && bus.w_tid == tid_q);
  assign sb_ok    = bus.sb_set && bus.sb_addr != '0 && !(clearing && bus.sb_tid == tid_q);
  // Clear sequencer: walk indices 1..DEPTH-1 of the latched thread, new requests ignored while busy
  always_comb begin
    state_d = clearing ? (last ? IDLE : CLEAR) : (bus.clr_req ? CLEAR : IDLE);
    cnt_d   = clearing ? (last ? '0 : cnt_q + 1'b1) : (bus.clr_req ? ADDR_W'(1) : '0);
    tid_d   = (!clearing && bus.clr_req) ? bus.clr_tid : tid_q;
  end
  // Array update: writeback and clear write clear busy, a same-cycle scoreboard set wins
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    if (wr_ok) begin
      mem_d[bus.w_tid][bus.w_addr]  = bus.w_data;
      busy_d[bus.w_tid][bus.w_addr] = 1'b0;
    end
    if (clearing) begin
      mem_d[tid_q][cnt_q]  = '0;
      busy_d[tid_q][cnt_q] = 1'b0;
    end
    if (sb_ok) busy_d[bus.sb_tid][bus.sb_addr] = 1'b1;
  end
  // State and storage registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tid_q   <= '0;
      mem_q   <= '{default: '0};
      busy_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tid_q   <= tid_d;
      mem_q   <= mem_d;
      busy_q  <= busy_d;
    end
  end
  // Read ports: register 0 hardwired to zero, accepted same-thread write bypassed, busy taken from flops only
  always_comb begin
    ra[0] = bus.r_addr_a;
    ra[1] = bus.r_addr_b;
    ra[2] = bus.r_addr_c;
    for (int i = 0; i < 3; i++) begin
      rd[i] = ra[i] == '0 ? '0 :
              (wr_ok && bus.w_tid == bus.r_tid && bus.w_addr == ra[i]) ? bus.w_data :
              mem_q[bus.r_tid][ra[i]];
      rb[i] = busy_q[bus.r_tid][ra[i]];
    end
  end
  assign bus.r_data_a = rd[0];
  assign bus.r_data_b = rd[1];
  assign bus.r_data_c = rd[2];
  assign bus.busy_a   = rb[0];
  assign bus.busy_b   = rb[1];
  assign bus.busy_c   = rb[2];
  assign bus.clr_busy = clearing;
  assign bus.clr_done = clearing && last;
endmodule

// File: tb/tb_gpu_regfile_mt.sv
// tb_gpu_regfile_mt: directed scoreboard bench for the default and a 1-thread/8-entry register file
module tb_gpu_regfile_mt;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  gpu_regfile_mt_if #(.DATA_W(64), .ADDR_W(5), .NUM_THR(4)) b1 ();
  gpu_regfile_mt_if #(.DATA_W(64), .ADDR_W(3), .NUM_THR(1)) b2 ();
  gpu_regfile_mt #(.DATA_W(64), .ADDR_W(5), .NUM_THR(4)) u1 (.clk(clk), .rst(rst), .bus(b1));
  gpu_regfile_mt #(.DATA_W(64), .ADDR_W(3), .NUM_THR(1)) u2 (.clk(clk), .rst(rst), .bus(b2));
  typedef struct {
    string       name;
    int          sel;
    logic [63:0] exp;
  } item_t;
  item_t q[$];
  int tests = 0;
  int fails = 0;
  localparam int RA = 0, RB = 1, RC = 2, BA = 3, BB = 4, BC = 5, CB = 6, CD = 7, D2 = 8;
  function automatic logic [63:0] act(input int sel);
    case (sel)
      0:  return b1.r_data_a;
      1:  return b1.r_data_b;
      2:  return b1.r_data_c;
      3:  return {63'b0, b1.busy_a};
      4:  return {63'b0, b1.busy_b};
      5:  return {63'b0, b1.busy_c};
      6:  return {63'b0, b1.clr_busy};
      7:  return {63'b0, b1.clr_done};
      8:  return b2.r_data_a;
      9:  return b2.r_data_b;
      10: return b2.r_data_c;
      11: return {63'b0, b2.busy_a};
      12: return {63'b0, b2.busy_b};
      13: return {63'b0, b2.busy_c};
      14: return {63'b0, b2.clr_busy};
      15: return {63'b0, b2.clr_done};
      default: return 64'hx;
    endcase
  endfunction
  always @(negedge clk) begin : monitor
    item_t it;
    logic [63:0] a;
    while (q.size() > 0) begin
      it = q.pop_front();
      a = act(it.sel);
      tests++;
      if (a !== it.exp) begin
        fails++;
        $display("FAIL %s @%0t: got %h expected %h", it.name, $time, a, it.exp);
      end
    end
  end
  task automatic ex(input string n, input int sel, input logic [63:0] v);
    item_t it;
    it.name = n;
    it.sel  = sel;
    it.exp  = v;
    q.push_back(it);
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
    b1.we = 1'b0; b1.sb_set = 1'b0; b1.clr_req = 1'b0;
    b2.we = 1'b0; b2.sb_set = 1'b0; b2.clr_req = 1'b0;
  endtask
  task automatic wr1(input int t, input int a, input logic [63:0] d);
    b1.we = 1'b1; b1.w_tid = 2'(t); b1.w_addr = 5'(a); b1.w_data = d;
  endtask
  task automatic sb1(input int t, input int a);
    b1.sb_set = 1'b1; b1.sb_tid = 2'(t); b1.sb_addr = 5'(a);
  endtask
  task automatic rd1(input int t, input int a, input int b, input int c);
    b1.r_tid = 2'(t); b1.r_addr_a = 5'(a); b1.r_addr_b = 5'(b); b1.r_addr_c = 5'(c);
  endtask
  task automatic wr2(input int a, input logic [63:0] d);
    b2.we = 1'b1; b2.w_tid = '0; b2.w_addr = 3'(a); b2.w_data = d;
  endtask
  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end
  initial begin
    b1.we = 0; b1.w_tid = 0; b1.w_addr = 0; b1.w_data = 0; b1.sb_set = 0; b1.sb_tid = 0;
    b1.sb_addr = 0; b1.clr_req = 0; b1.clr_tid = 0; rd1(0, 7, 0, 0);
    b2.we = 0; b2.w_tid = 0; b2.w_addr = 0; b2.w_data = 0; b2.sb_set = 0; b2.sb_tid = 0;
    b2.sb_addr = 0; b2.clr_req = 0; b2.clr_tid = 0;
    b2.r_tid = 0; b2.r_addr_a = 0; b2.r_addr_b = 0; b2.r_addr_c = 0;
    cyc();
    rst = 1'b0;
    ex("rst_data", RA, 0); ex("rst_busy", BA, 0); ex("rst_clr_busy", CB, 0); ex("rst_clr_done", CD, 0);
    ex("rst2_clr_busy", D2 + CB, 0);
    cyc(); wr1(1, 7, 64'hDEADBEEF); rd1(1, 7, 0, 7);
    ex("bypass_a", RA, 64'hDEADBEEF); ex("bypass_r0", RB, 0); ex("bypass_c", RC, 64'hDEADBEEF);
    cyc(); rd1(0, 7, 7, 7); ex("tid0_r7", RA, 0);
    cyc(); rd1(1, 7, 7, 7); ex("tid1_r7_stored", RB, 64'hDEADBEEF);
    cyc(); wr1(2, 0, 64'h55); sb1(2, 0); rd1(2, 0, 0, 0); ex("r0_no_bypass", RA, 0);
    cyc(); ex("r0_reads_zero", RA, 0); ex("r0_not_busy", BA, 0);
    cyc(); sb1(2, 3); rd1(2, 3, 3, 3); ex("sb_no_bypass", BA, 0);
    cyc(); ex("sb_set_busy", BA, 1);
    cyc(); wr1(2, 3, 64'h33); sb1(2, 3); ex("wr_sb_bypass", RA, 64'h33); ex("wr_sb_busy_now", BA, 1);
    cyc(); ex("set_wins_busy", BA, 1); ex("set_wins_data", RB, 64'h33);
    cyc(); wr1(2, 3, 64'h44); ex("wr_clear_no_bypass", BA, 1);
    cyc(); ex("wr_clears_busy", BA, 0); ex("wr_data_44", RA, 64'h44);
    for (int i = 1; i < 32; i++) begin
      cyc(); wr1(3, i, 64'h1000 + 64'(i));
    end
    cyc(); wr1(0, 5, 64'hABCD);
    cyc(); b1.clr_req = 1'b1; b1.clr_tid = 2'd3; rd1(3, 31, 1, 30);
    ex("clr_req_idle_busy", CB, 0); ex("clr_req_idle_done", CD, 0); ex("fill_r31", RA, 64'h101F);
    for (int k = 1; k <= 31; k++) begin
      cyc();
      if (k == 5) begin b1.clr_req = 1'b1; b1.clr_tid = 2'd0; end
      if (k == 1) wr1(0, 6, 64'h66);
      if (k == 25) begin wr1(3, 20, 64'hFFFF); rd1(3, 20, 1, 30); ex("clr_wr_no_bypass", RA, 0); end
      if (k == 27) sb1(3, 25);
      if (k == 2) begin ex("clr_mid_r1_zero", RB, 0); ex("clr_mid_r30_old", RC, 64'h101E); end
      ex($sformatf("clr_busy_k%0d", k), CB, 1);
      ex($sformatf("clr_done_k%0d", k), CD, (k == 31) ? 64'd1 : 64'd0);
    end
    cyc(); rd1(3, 20, 25, 25);
    ex("clr_end_busy", CB, 0); ex("clr_end_done", CD, 0); ex("clr_wr_lost", RA, 0);
    ex("clr_sb_dropped", BB, 0); ex("clr_r25", RC, 0);
    cyc(); ex("clr_req_not_queued", CB, 0);
    for (int j = 0; j < 11; j++) begin
      cyc(); rd1(3, 3 * j + 1, (3 * j + 2 > 31) ? 31 : 3 * j + 2, (3 * j + 3 > 31) ? 31 : 3 * j + 3);
      ex("tid3_zero_a", RA, 0); ex("tid3_zero_b", RB, 0); ex("tid3_zero_c", RC, 0);
    end
    cyc(); rd1(0, 5, 6, 7);
    ex("tid0_r5_intact", RA, 64'hABCD); ex("tid0_r6_during_clr", RB, 64'h66); ex("tid0_r7", RC, 0);
    cyc(); wr1(1, 2, 64'h22);
    cyc(); sb1(1, 9);
    cyc(); b1.clr_req = 1'b1; b1.clr_tid = 2'd3;
    for (int k = 1; k < 10; k++) begin
      cyc(); rd1(1, 7, 2, 9); ex("rstclr_busy", CB, 1);
      if (k == 1) begin ex("pre_rst_r2", RB, 64'h22); ex("pre_rst_busy9", BC, 1); end
    end
    cyc(); rst = 1'b1; wr1(0, 4, 64'h77); sb1(0, 8); b1.clr_req = 1'b1;
    ex("rst_cycle_done", CD, 0);
    cyc(); rst = 1'b0; rd1(1, 7, 2, 9);
    ex("after_rst_busy", CB, 0); ex("after_rst_done", CD, 0); ex("after_rst_r7", RA, 0);
    ex("after_rst_r2", RB, 0); ex("after_rst_busy9", BC, 0);
    cyc(); rd1(0, 5, 4, 8);
    ex("after_rst_r5", RA, 0); ex("rst_prio_we", RB, 0); ex("rst_prio_sb", BC, 0);
    ex("rst_prio_clr", CB, 0);
    cyc(); wr2(5, 64'h1234); b2.r_addr_a = 3'd5; ex("s_bypass", D2 + RA, 64'h1234);
    cyc(); wr2(0, 64'h55); b2.sb_set = 1'b1; b2.sb_addr = 3'd0; b2.r_addr_a = 3'd0; b2.r_addr_b = 3'd5;
    ex("s_r0_no_bypass", D2 + RA, 0); ex("s_r5_stored", D2 + RB, 64'h1234);
    cyc(); ex("s_r0_zero", D2 + RA, 0); ex("s_r0_not_busy", D2 + BA, 0);
    cyc(); b2.sb_set = 1'b1; b2.sb_addr = 3'd2; b2.r_addr_a = 3'd2; ex("s_sb_no_bypass", D2 + BA, 0);
    cyc(); ex("s_sb_busy", D2 + BA, 1);
    cyc(); wr2(2, 64'h22); b2.sb_set = 1'b1; b2.sb_addr = 3'd2; ex("s_wr_sb_bypass", D2 + RA, 64'h22);
    cyc(); ex("s_set_wins", D2 + BA, 1);
    for (int i = 1; i < 8; i++) begin
      cyc(); wr2(i, 64'h200 + 64'(i));
    end
    cyc(); b2.clr_req = 1'b1; b2.r_addr_a = 3'd7; ex("s_clr_idle", D2 + CB, 0); ex("s_fill_r7", D2 + RA, 64'h207);
    for (int k = 1; k <= 7; k++) begin
      cyc(); ex("s_clr_busy", D2 + CB, 1); ex($sformatf("s_clr_done_k%0d", k), D2 + CD, (k == 7) ? 64'd1 : 64'd0);
    end
    cyc(); b2.r_addr_a = 3'd1; b2.r_addr_b = 3'd4; b2.r_addr_c = 3'd7;
    ex("s_clr_end", D2 + CB, 0); ex("s_clr_end_done", D2 + CD, 0);
    ex("s_zero_1", D2 + RA, 0); ex("s_zero_4", D2 + RB, 0); ex("s_zero_7", D2 + RC, 0);
    cyc(); b2.r_addr_a = 3'd2; b2.r_addr_b = 3'd5; b2.r_addr_c = 3'd6;
    ex("s_zero_2", D2 + RA, 0); ex("s_zero_5", D2 + RB, 0); ex("s_zero_6", D2 + RC, 0);
    cyc(); b2.r_addr_a = 3'd3; ex("s_zero_3", D2 + RA, 0); ex("s_not_busy_2", D2 + BA, 0);
    cyc();
    @(negedge clk);
    #1;
    tests++;
    if (b2.r_data_a !== 64'd0) begin
      fails++;
      $display("FAIL s_final_r3 @%0t: got %h expected 0", $time, b2.r_data_a);
    end
    tests++;
    if (b1.clr_busy !== 1'b0) begin
      fails++;
      $display("FAIL final_clr_idle @%0t: got %b expected 0", $time, b1.clr_busy);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/gpu_regfile_mt.md
GPU_REGFILE_MT -- requirements
Module: gpu_regfile_mt

Interface
REQ-001 Parameter DATA_W, default 64, register width in bits.
REQ-002 Parameter ADDR_W, default 5, register index width; 2**ADDR_W registers per thread.
REQ-003 Parameter NUM_THR, default 4, thread count; TID_W = max(1, clog2(NUM_THR)).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 we, w_tid, w_addr, w_data  in  1/TID_W/ADDR_W/DATA_W  writeback port.
REQ-007 r_tid  in  TID_W  thread selected for all three read ports.
REQ-008 r_addr_a, r_addr_b, r_addr_c  in  ADDR_W  read indices.
REQ-009 r_data_a, r_data_b, r_data_c  out  DATA_W  read data.
REQ-010 busy_a, busy_b, busy_c  out  1  scoreboard pending-write flag per read port.
REQ-011 sb_set, sb_tid, sb_addr  in  1/TID_W/ADDR_W  mark destination register pending at issue.
REQ-012 clr_req, clr_tid  in  1/TID_W  request zeroing of one thread's register bank.
REQ-013 clr_busy  out  1  high while a bank clear is in progress.
REQ-014 clr_done  out  1  one-cycle pulse on final clear write.

Function
REQ-015 Storage: NUM_THR banks x 2**ADDR_W entries x DATA_W bits, plus one busy bit per entry.
REQ-016 Register 0 of every thread reads 0, is never busy; writes and sb_set to index 0 are ignored.
REQ-017 Reads combinational, zero cycle latency, from bank r_tid.
REQ-018 Write-through bypass: if we, w_tid==r_tid, w_addr==r_addr_x, w_addr!=0, and the write is accepted (REQ-024), r_data_x = w_data same cycle.
REQ-019 Accepted write updates bank[w_tid][w_addr] at the clock edge and clears its busy bit.
REQ-020 sb_set sets busy[sb_tid][sb_addr] at the clock edge; on same-entry collision with a write-clear, set wins.
REQ-021 busy_x = registered busy[r_tid][r_addr_x]; no bypass of same-cycle set/clear.
REQ-022 Clear FSM states IDLE, CLEAR; IDLE->CLEAR on clr_req, latching clr_tid and loading index counter with 1.
REQ-023 In CLEAR: each cycle write 0 to bank[latched tid][cnt], clear its busy bit, increment cnt; at cnt==2**ADDR_W-1 pulse clr_done and return to IDLE; total 2**ADDR_W-1 cycles.
REQ-024 In CLEAR, external writes and sb_set targeting the latched tid are dropped (no bypass); other threads unaffected.
REQ-025 clr_busy = (state==CLEAR); clr_req while CLEAR is ignored, not queued.
REQ-026 Reads of the clearing thread during CLEAR return current array contents (mix of old and zeroed).
REQ-027 Counter wraps never; exit occurs on terminal index only.

Reset
REQ-028 rst in any state, including mid-CLEAR: all entries 0, all busy bits 0, FSM IDLE, cnt 0, clr_busy 0, clr_done 0 after that edge.
REQ-029 rst has priority over we, sb_set, clr_req in the same cycle.

Verification
REQ-030 Write tid1 r7=0xDEADBEEF, read tid1 r7 same cycle -> r_data=0xDEADBEEF (bypass); tid0 r7 -> 0.
REQ-031 Write r0=0x55 any tid -> r_data reads 0 next cycle; sb_set r0 -> busy 0.
REQ-032 sb_set tid2 r3, next cycle busy_a=1; write tid2 r3 with sb_set tid2 r3 same cycle -> busy stays 1.
REQ-033 Fill tid3 r1..r31 nonzero, clr_req tid3 -> clr_busy 1 for 31 cycles, clr_done pulses once on cycle 31, all tid3 regs read 0, tid0 data intact, write to tid3 during CLEAR lost.
REQ-034 rst asserted at cycle 10 of CLEAR -> next cycle clr_busy 0, all banks 0, no clr_done pulse.
REQ-035 NUM_THR=1, ADDR_W=3 instance: clear takes 7 cycles, bypass and scoreboard behave as above.
